// File: rtl/dm_store_buffer.sv
// rtl/dm_store_buffer.sv - posted-write store buffer between MEM stage and data memory
// Optional build macro: STBUF_COALESCE_EN (merge a store into the youngest entry when
// it targets the same word; undefined by default, every accepted store allocates).
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_pc4,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_ready,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic [31:0]      ld_data,
    input  logic             dm_busy,
    output logic             dm_we,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wd,
    output logic [31:0]      dm_pc4,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);

    logic [31:0]      r_pc4  [DEPTH];
    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic [PTR_W-1:0] w_tail_m1;
    logic             w_empty;
    logic             w_dm_we;
    logic             w_accept;
    logic             w_coalesce;
    logic             w_push;
    logic             w_update;
    logic             w_hit;
    logic [31:0]      w_fwd;
    logic [PTR_W-1:0] w_idx;
    logic             w_unused_bits;

    // Only word-index bits of the load address take part in matching.
    assign w_unused_bits = ^{ld_addr[31:12], ld_addr[1:0]};

    assign w_tail_m1 = r_tail - PTR_W'(1);
    assign w_empty   = (r_count == '0);
    // Reset cycle must never commit a DM write, even with entries pending.
    assign w_dm_we   = !w_empty && !dm_busy && !reset;
    assign w_accept  = st_valid && st_ready;

`ifdef STBUF_COALESCE_EN
    // Merge into the youngest entry unless that entry is the head leaving this cycle.
    assign w_coalesce = !w_empty
                     && (r_addr[w_tail_m1][11:2] == st_addr[11:2])
                     && !((r_count == (PTR_W+1)'(1)) && w_dm_we);
`else
    assign w_coalesce = 1'b0;
`endif

    assign w_push   = w_accept && !w_coalesce;
    assign w_update = w_accept && w_coalesce;

    assign st_ready = (r_count < LP_DEPTH);
    assign empty    = w_empty;
    assign count    = r_count;
    assign dm_we    = w_dm_we;
    assign dm_addr  = w_empty ? 32'h0 : r_addr[r_head];
    assign dm_wd    = w_empty ? 32'h0 : r_data[r_head];
    assign dm_pc4   = w_empty ? 32'h0 : r_pc4[r_head];
    assign ld_hit   = w_hit;
    assign ld_data  = w_fwd;

    // Walk entries oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = 32'h0;
        w_idx = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (((PTR_W+1)'(i) < r_count) && (r_addr[w_idx][11:2] == ld_addr[11:2])) begin
                w_hit = 1'b1;
                w_fwd = r_data[w_idx];
            end
        end
    end

    // Entry storage needs no reset: validity is defined purely by head/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc4[r_tail]  <= st_pc4;
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end else if (w_update) begin
            r_pc4[w_tail_m1]  <= st_pc4;
            r_data[w_tail_m1] <= st_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)  r_tail <= r_tail + PTR_W'(1);
            if (w_dm_we) r_head <= r_head + PTR_W'(1);
            case ({w_push, w_dm_we})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb/tb_dm_store_buffer.sv - directed self-checking bench for dm_store_buffer
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_pc4;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        dm_busy;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc4;
    logic [2:0]  count;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    dm_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_pc4(st_pc4), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .dm_busy(dm_busy), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc4(dm_pc4),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Inputs settle at edge+1, so the negedge sample is what the next posedge commits.
    always @(negedge clk) begin
        if (dm_we) got_q.push_back({dm_addr, dm_wd});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_pc4   = a + 32'h104;
    endtask

    initial begin
        reset = 1'b1; drive_st(1'b0, 32'h0, 32'h0); ld_addr = 32'h0; dm_busy = 1'b0;
        cyc(); cyc();
        #1;
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_st_ready", st_ready, 1);
            chk("idle_empty", empty, 1);
            chk("idle_dm_we", dm_we, 0);
            chk("idle_count", count, 0);
            chk("idle_ld_hit", ld_hit, 0);
            cyc();
        end

        // Single store: not drained or forwarded in its own cycle
        drive_st(1'b1, 32'h10, 32'hDEADBEEF); ld_addr = 32'h10;
        #1;
        chk("single_same_cycle_we", dm_we, 0);
        chk("single_same_cycle_hit", ld_hit, 0);
        cyc();
        drive_st(1'b0, 32'h0, 32'h0);
        #1;
        chk("single_we", dm_we, 1);
        chk("single_addr", dm_addr, 32'h10);
        chk("single_wd", dm_wd, 32'hDEADBEEF);
        chk("single_pc4", dm_pc4, 32'h114);
        chk("single_fwd_hit", ld_hit, 1);
        chk("single_fwd_data", ld_data, 32'hDEADBEEF);
        exp_q.push_back({32'h10, 32'hDEADBEEF});
        cyc();
        #1;
        chk("single_empty_after", empty, 1);
        chk("single_we_after", dm_we, 0);

        // Fill under dm_busy, fifth store held off, then drain in order
        dm_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 32'(i*4), 32'hA000 + 32'(i));
            exp_q.push_back({32'(i*4), 32'hA000 + 32'(i)});
            cyc();
        end
        drive_st(1'b1, 32'h30, 32'h5555);
        #1;
        chk("full_count", count, 4);
        chk("full_st_ready", st_ready, 0);
        chk("busy_dm_we", dm_we, 0);
        cyc();
        #1;
        chk("full_held_count", count, 4);
        drive_st(1'b0, 32'h0, 32'h0);
        ld_addr = 32'h8;
        #1;
        chk("full_fwd_hit", ld_hit, 1);
        chk("full_fwd_data", ld_data, 32'hA002);
        dm_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_we", dm_we, 1);
            chk("drain_addr", dm_addr, 32'(i*4));
            cyc();
        end
        #1;
        chk("drain_empty", empty, 1);

        // Same-word stores and forwarding of the youngest
        dm_busy = 1'b1;
        drive_st(1'b1, 32'h20, 32'h1); cyc();
        drive_st(1'b1, 32'h20, 32'h2); cyc();
        drive_st(1'b0, 32'h0, 32'h0);
        ld_addr = 32'h20;
        #1;
        chk("fwd_hit", ld_hit, 1);
        chk("fwd_youngest", ld_data, 32'h2);
`ifdef STBUF_COALESCE_EN
        chk("coalesce_count", count, 1);
        exp_q.push_back({32'h20, 32'h2});
`else
        chk("nocoalesce_count", count, 2);
        exp_q.push_back({32'h20, 32'h1});
        exp_q.push_back({32'h20, 32'h2});
`endif
        ld_addr = 32'h24;
        #1;
        chk("miss_hit", ld_hit, 0);
        chk("miss_data", ld_data, 32'h0);
        ld_addr = 32'h1022;
        #1;
        chk("alias_hit", ld_hit, 1);
        chk("alias_data", ld_data, 32'h2);
        dm_busy = 1'b0;
        for (int i = 0; i < 6 && !empty; i++) cyc();
        #1;
        chk("fwd_drained", empty, 1);

        // Full buffer, drain enabled, store held until a slot frees
        dm_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 32'h40 + 32'(i*4), 32'hB000 + 32'(i));
            exp_q.push_back({32'h40 + 32'(i*4), 32'hB000 + 32'(i)});
            cyc();
        end
        drive_st(1'b1, 32'h50, 32'hB004);
        exp_q.push_back({32'h50, 32'hB004});
        dm_busy = 1'b0;
        #1;
        chk("hold_ready_full", st_ready, 0);
        chk("hold_count_full", count, 4);
        chk("hold_we_full", dm_we, 1);
        cyc();
        #1;
        chk("hold_count_pop", count, 3);
        chk("hold_ready_pop", st_ready, 1);
        cyc();
        drive_st(1'b0, 32'h0, 32'h0);
        #1;
        chk("pushpop_count", count, 3);
        for (int i = 0; i < 8 && !empty; i++) cyc();
        #1;
        chk("hold_drained", empty, 1);

        // Reset with pending stores discards them
        dm_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_st(1'b1, 32'h60 + 32'(i*4), 32'hC000 + 32'(i));
            cyc();
        end
        drive_st(1'b0, 32'h0, 32'h0);
        #1;
        chk("prereset_count", count, 3);
        reset = 1'b1; dm_busy = 1'b0;
        #1;
        chk("reset_cycle_we", dm_we, 0);
        cyc();
        reset = 1'b0;
        #1;
        chk("postreset_count", count, 0);
        chk("postreset_we", dm_we, 0);
        chk("postreset_empty", empty, 1);
        for (int i = 0; i < 4; i++) cyc();

        // Every DM write, in program order, and nothing else
        chk("log_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                chk("log_addr", got_q[i][63:32], exp_q[i][63:32]);
                chk("log_data", got_q[i][31:0], exp_q[i][31:0]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
